// File: rtl/vga_scan_gen.sv
// vga_scan_gen: 640x480@60 raster counter with sync, grid-cell,
// border/blanking classification and a once-per-frame tick.
module vga_scan_gen #(
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter int unsigned CELL_LOG2    = 4,
  parameter int unsigned BORDER_CELLS = 1
) (
  input  logic       in_clk,
  input  logic       in_reset,
  input  logic       in_pix_en,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic [9:0] out_x,
  output logic [9:0] out_y,
  output logic [5:0] out_cell_x,
  output logic [4:0] out_cell_y,
  output logic       out_oobounds,
  output logic       out_border,
  output logic       out_frame_tick
);

  localparam int unsigned H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned GRID_W = H_VISIBLE >> CELL_LOG2;
  localparam int unsigned GRID_H = V_VISIBLE >> CELL_LOG2;

  localparam logic [9:0] L_H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] L_H_LV   = 10'(H_VISIBLE - 1);
  localparam logic [9:0] L_H_SB   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] L_H_SE   =
    10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] L_H_LAST = 10'(H_TOTAL - 1);

  localparam logic [9:0] L_V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] L_V_LV   = 10'(V_VISIBLE - 1);
  localparam logic [9:0] L_V_SB   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] L_V_SE   =
    10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] L_V_LAST = 10'(V_TOTAL - 1);

  localparam logic [9:0] L_B_LO  = 10'(BORDER_CELLS);
  localparam logic [9:0] L_CX_HI = 10'(GRID_W - BORDER_CELLS);
  localparam logic [9:0] L_CY_HI = 10'(GRID_H - BORDER_CELLS);

  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_hsync;
  logic       r_vsync;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic [5:0] r_cx;
  logic [4:0] r_cy;
  logic       r_oob;
  logic       r_border;
  logic       r_tick;

  logic [9:0] w_cx;
  logic [9:0] w_cy;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_oob;
  logic       w_edge;
  logic       w_hsync;
  logic       w_vsync;
  logic       w_last_vis;

  assign w_cx     = r_h >> CELL_LOG2;
  assign w_cy     = r_v >> CELL_LOG2;
  assign w_h_last = (r_h == L_H_LAST);
  assign w_v_last = (r_v == L_V_LAST);
  assign w_oob    = (r_h >= L_H_VIS) | (r_v >= L_V_VIS);
  assign w_edge   = (w_cx < L_B_LO) | (w_cx >= L_CX_HI) |
                    (w_cy < L_B_LO) | (w_cy >= L_CY_HI);
  assign w_hsync  = !((r_h >= L_H_SB) && (r_h <= L_H_SE));
  assign w_vsync  = !((r_v >= L_V_SB) && (r_v <= L_V_SE));
  assign w_last_vis = (r_h == L_H_LV) && (r_v == L_V_LV);

  always_ff @(posedge in_clk) begin
    if (!in_reset) begin
      r_h      <= '0;
      r_v      <= '0;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
      r_x      <= '0;
      r_y      <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_oob    <= 1'b1;
      r_border <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      // tick lasts one clock whatever the strobe duty cycle
      r_tick <= in_pix_en & w_last_vis;
      if (in_pix_en) begin
        r_hsync  <= w_hsync;
        r_vsync  <= w_vsync;
        r_x      <= r_h;
        r_y      <= r_v;
        r_cx     <= w_cx[5:0];
        r_cy     <= w_cy[4:0];
        r_oob    <= w_oob;
        r_border <= !w_oob & w_edge;
        r_h      <= w_h_last ? '0 : r_h + 10'd1;
        if (w_h_last)
          r_v <= w_v_last ? '0 : r_v + 10'd1;
      end
    end
  end

  assign out_hsync      = r_hsync;
  assign out_vsync      = r_vsync;
  assign out_x          = r_x;
  assign out_y          = r_y;
  assign out_cell_x     = r_cx;
  assign out_cell_y     = r_cy;
  assign out_oobounds   = r_oob;
  assign out_border     = r_border;
  assign out_frame_tick = r_tick;

endmodule
